load_queue: RTL and testbench

Parametrised, in-order load queue for the Tomasulo datapath. It accepts loads from issue control, holds each load's base-register value or ROB tag, and snoops the CDB until the base resolves. It then issues data-cache reads strictly in program order from the head entry and presents each loaded value, tagged with its destination ROB entry, to the CDB arbiter. It replaces the fixed four-entry load buffer. It adds configurable depth and width, same-cycle CDB bypass at issue, a full dcache request/response handshake, CDB-request handshaking, and flush-safe draining of an outstanding read.

---
 rtl/load_queue_if.sv | 47 ++++
 rtl/load_queue.sv | 166 ++++++++++++++++
 tb/tb_load_queue.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_queue_if.sv
// Bundles every handshake and bus signal of the load queue.
// master: issue control, CDB, dcache and CDB arbiter side (drives requests/responses).
// slave : the load queue itself.
// Signals:
//   flush                                     discard all entries
//   issue_we/base_valid/base_tag/base/offset/dest   new load written at tail
//   full, empty                               occupancy status
//   cdb_valid/tag/data                        common data bus broadcast
//   dmem_read/address, dmem_resp/rdata        dcache read handshake
//   res_valid/tag/data, res_ack               result offered to the CDB arbiter
interface load_queue_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned TAG_WIDTH  = 3
);
  logic                  flush;
  logic                  issue_we;
  logic                  issue_base_valid;
  logic [TAG_WIDTH-1:0]  issue_base_tag;
  logic [DATA_WIDTH-1:0] issue_base;
  logic [DATA_WIDTH-1:0] issue_offset;
  logic [TAG_WIDTH-1:0]  issue_dest;
  logic                  full;
  logic                  empty;
  logic                  cdb_valid;
  logic [TAG_WIDTH-1:0]  cdb_tag;
  logic [DATA_WIDTH-1:0] cdb_data;
  logic                  dmem_read;
  logic [DATA_WIDTH-1:0] dmem_address;
  logic                  dmem_resp;
  logic [DATA_WIDTH-1:0] dmem_rdata;
  logic                  res_valid;
  logic [TAG_WIDTH-1:0]  res_tag;
  logic [DATA_WIDTH-1:0] res_data;
  logic                  res_ack;

  modport master (
    output flush, issue_we, issue_base_valid, issue_base_tag, issue_base, issue_offset,
           issue_dest, cdb_valid, cdb_tag, cdb_data, dmem_resp, dmem_rdata, res_ack,
    input  full, empty, dmem_read, dmem_address, res_valid, res_tag, res_data
  );

  modport slave (
    input  flush, issue_we, issue_base_valid, issue_base_tag, issue_base, issue_offset,
           issue_dest, cdb_valid, cdb_tag, cdb_data, dmem_resp, dmem_rdata, res_ack,
    output full, empty, dmem_read, dmem_address, res_valid, res_tag, res_data
  );
endinterface

// File: rtl/load_queue.sv
// In-order load queue for the Tomasulo datapath.
// Loads enter at the tail with either a resolved base or the ROB tag that will produce it,
// snoop the CDB until the base resolves, and are serviced strictly from the head: one
// dcache read at a time, result held for the CDB arbiter until granted.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  load_queue_if.slave (issue, status, CDB snoop, dcache, result handshake)
module load_queue #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned TAG_WIDTH  = 3,
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input logic         clk,
  input logic         rst,
  load_queue_if.slave bus
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PtrOne    = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   CountOne  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2:0]   CountFull = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StRead, StWb, StDrain} state_e;

  logic                  busy_q       [DEPTH];
  logic                  base_valid_q [DEPTH];
  logic [DATA_WIDTH-1:0] base_q       [DEPTH];
  logic [TAG_WIDTH-1:0]  tag_q        [DEPTH];
  logic [DATA_WIDTH-1:0] offset_q     [DEPTH];
  logic [TAG_WIDTH-1:0]  dest_q       [DEPTH];

  logic [DEPTH_LOG2-1:0] head_q, tail_q;
  logic [DEPTH_LOG2:0]   count_q;
  state_e                state_q;
  logic                  dmem_read_q;
  logic [DATA_WIDTH-1:0] dmem_address_q;
  logic                  res_valid_q;
  logic [TAG_WIDTH-1:0]  res_tag_q;
  logic [DATA_WIDTH-1:0] res_data_q;

  logic                  full, push, pop, bypass, head_ready;
  logic [DATA_WIDTH-1:0] head_address;

  assign full         = (count_q == CountFull);
  assign bypass       = !bus.issue_base_valid && bus.cdb_valid &&
                        (bus.cdb_tag == bus.issue_base_tag);
  // Status comes from the registered count, so a same-cycle pop never frees a slot for issue.
  assign push         = bus.issue_we && !full && !bus.flush;
  assign pop          = (state_q == StWb) && bus.res_ack;
  assign head_ready   = busy_q[head_q] && base_valid_q[head_q];
  assign head_address = base_q[head_q] + offset_q[head_q];

  assign bus.full         = full;
  assign bus.empty        = (count_q == '0);
  assign bus.dmem_read    = dmem_read_q;
  assign bus.dmem_address = dmem_address_q;
  assign bus.res_valid    = res_valid_q;
  assign bus.res_tag      = res_tag_q;
  assign bus.res_data     = res_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        busy_q[i]       <= 1'b0;
        base_valid_q[i] <= 1'b0;
        base_q[i]       <= '0;
        tag_q[i]        <= '0;
        offset_q[i]     <= '0;
        dest_q[i]       <= '0;
      end
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      state_q        <= StIdle;
      dmem_read_q    <= 1'b0;
      dmem_address_q <= '0;
      res_valid_q    <= 1'b0;
      res_tag_q      <= '0;
      res_data_q     <= '0;
    end else begin
      // CDB snoop: any number of waiting entries may capture the same broadcast.
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (busy_q[i] && !base_valid_q[i] && bus.cdb_valid && (tag_q[i] == bus.cdb_tag)) begin
          base_q[i]       <= bus.cdb_data;
          base_valid_q[i] <= 1'b1;
        end
      end

      // The tail entry is never busy when not full, so this cannot collide with the snoop.
      if (push) begin
        busy_q[tail_q]       <= 1'b1;
        base_valid_q[tail_q] <= bus.issue_base_valid || bypass;
        base_q[tail_q]       <= bypass ? bus.cdb_data : bus.issue_base;
        tag_q[tail_q]        <= bus.issue_base_tag;
        offset_q[tail_q]     <= bus.issue_offset;
        dest_q[tail_q]       <= bus.issue_dest;
        tail_q               <= tail_q + PtrOne;
      end

      case (state_q)
        StIdle: begin
          if (head_ready) begin
            state_q        <= StRead;
            dmem_read_q    <= 1'b1;
            dmem_address_q <= head_address;
          end
        end
        StRead: begin
          if (bus.dmem_resp) begin
            state_q     <= StWb;
            dmem_read_q <= 1'b0;
            res_valid_q <= 1'b1;
            res_tag_q   <= dest_q[head_q];
            res_data_q  <= bus.dmem_rdata;
          end
        end
        StWb: begin
          if (bus.res_ack) begin
            state_q        <= StIdle;
            res_valid_q    <= 1'b0;
            busy_q[head_q] <= 1'b0;
            head_q         <= head_q + PtrOne;
          end
        end
        StDrain: begin
          if (bus.dmem_resp) begin
            state_q     <= StIdle;
            dmem_read_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase

      if (push && !pop) begin
        count_q <= count_q + CountOne;
      end else if (pop && !push) begin
        count_q <= count_q - CountOne;
      end

      if (bus.flush) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          busy_q[i] <= 1'b0;
        end
        head_q      <= '0;
        tail_q      <= '0;
        count_q     <= '0;
        res_valid_q <= 1'b0;
        // An in-flight read must finish its handshake; a response arriving in the flush cycle
        // itself completes it, otherwise keep requesting until the dcache answers.
        if ((state_q == StRead) || (state_q == StDrain)) begin
          if (bus.dmem_resp) begin
            state_q     <= StIdle;
            dmem_read_q <= 1'b0;
          end else begin
            state_q     <= StDrain;
            dmem_read_q <= 1'b1;
          end
        end else begin
          state_q     <= StIdle;
          dmem_read_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_load_queue.sv
module tb_load_queue;
  localparam int unsigned DW = 16;
  localparam int unsigned TW = 3;

  logic clk;
  logic rst;

  load_queue_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) lq ();

  load_queue #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .DEPTH_LOG2(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (lq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic          base_valid;
    logic [TW-1:0] base_tag;
    logic [DW-1:0] base;
    logic [DW-1:0] offset;
    logic [TW-1:0] dest;
    int            cdb_delay;  // 0: bypass at issue when base not valid
    logic [DW-1:0] cdb_data;
    int            lat;        // dcache latency in cycles
    logic [DW-1:0] exp_addr;
  } vec_t;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
  } res_t;

  res_t sb[$];
  vec_t vecs [6];
  int   n_pass  = 0;
  int   n_total = 0;
  int   dlat    = 1;
  logic resp_en = 1'b0;

  function automatic logic [DW-1:0] mem_fn(input logic [DW-1:0] a);
    if (a == 16'h1004) return 16'hBEEF;
    return (a ^ 16'h5A5A) + 16'h0101;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // dcache model: answers after dmem_read has been high for dlat cycles.
  initial begin
    int cnt = 0;
    forever begin
      @(negedge clk);
      if (resp_en) begin
        lq.dmem_resp = 1'b0;
        if (lq.dmem_read) begin
          cnt++;
          if (cnt >= dlat) begin
            lq.dmem_resp  = 1'b1;
            lq.dmem_rdata = mem_fn(lq.dmem_address);
            cnt = 0;
          end
        end else begin
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic drain(input int n);
    int   got = 0;
    int   budget = 200;
    res_t e;
    while (got < n && budget > 0) begin
      if (lq.res_valid) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL sb_underflow: unexpected result tag %h data %h", lq.res_tag, lq.res_data);
          e = '0;
        end else begin
          e = sb.pop_front();
        end
        check("res_tag", 32'(lq.res_tag), 32'(e.tag));
        check("res_data", 32'(lq.res_data), 32'(e.data));
        tick();
        check("res_hold_valid", 32'(lq.res_valid), 1);
        check("res_hold_tag", 32'(lq.res_tag), 32'(e.tag));
        lq.res_ack = 1'b1;
        tick();
        lq.res_ack = 1'b0;
        got++;
      end else begin
        tick();
        budget--;
      end
    end
    check("drain_count", got, n);
  endtask

  task automatic issue(input logic bv, input logic [TW-1:0] btag, input logic [DW-1:0] base,
                       input logic [DW-1:0] off, input logic [TW-1:0] dest);
    lq.issue_we         = 1'b1;
    lq.issue_base_valid = bv;
    lq.issue_base_tag   = btag;
    lq.issue_base       = base;
    lq.issue_offset     = off;
    lq.issue_dest       = dest;
  endtask

  task automatic run_vec(input vec_t v);
    int   lat;
    logic early;
    dlat = v.lat;
    issue(v.base_valid, v.base_tag, v.base, v.offset, v.dest);
    if (!v.base_valid && v.cdb_delay == 0) begin
      lq.cdb_valid = 1'b1;
      lq.cdb_tag   = v.base_tag;
      lq.cdb_data  = v.cdb_data;
    end
    sb.push_back('{tag: v.dest, data: mem_fn(v.exp_addr)});
    tick();
    lq.issue_we  = 1'b0;
    lq.cdb_valid = 1'b0;
    if (!v.base_valid && v.cdb_delay > 0) begin
      early = 1'b0;
      for (int i = 0; i < v.cdb_delay; i++) begin
        lq.cdb_valid = 1'b1;
        lq.cdb_tag   = v.base_tag + 3'd1;
        lq.cdb_data  = 16'hDEAD;
        tick();
        lq.cdb_valid = 1'b0;
        if (lq.dmem_read) early = 1'b1;
      end
      check("no_early_read", 32'(early), 0);
      lq.cdb_valid = 1'b1;
      lq.cdb_tag   = v.base_tag;
      lq.cdb_data  = v.cdb_data;
      tick();
      lq.cdb_valid = 1'b0;
    end
    lat = 0;
    while (!lq.dmem_read && lat < 20) begin
      tick();
      lat++;
    end
    check("read_latency", lat, 1);
    check("dmem_address", 32'(lq.dmem_address), 32'(v.exp_addr));
    drain(1);
    check("empty_after", 32'(lq.empty), 1);
  endtask

  initial begin
    logic [DW-1:0] full_addr [4];
    logic          seen;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] full_addr [4];
    logic          seen;
    vecs[0] = '{1'b1, 3'd0, 16'h1000, 16'h0004, 3'd5, 0, 16'h0000, 3, 16'h1004};
    vecs[1] = '{1'b0, 3'd2, 16'hFFFF, 16'h0010, 3'd6, 5, 16'h2000, 1, 16'h2010};
    vecs[2] = '{1'b0, 3'd2, 16'hFFFF, 16'h0010, 3'd7, 0, 16'h2000, 1, 16'h2010};
    vecs[3] = '{1'b1, 3'd4, 16'hFFFE, 16'h0004, 3'd3, 0, 16'h0000, 2, 16'h0002};
    vecs[4] = '{1'b0, 3'd6, 16'h1234, 16'hFFFF, 3'd1, 2, 16'h8000, 1, 16'h7FFF};
    vecs[5] = '{1'b1, 3'd0, 16'h0000, 16'h0000, 3'd0, 0, 16'h0000, 4, 16'h0000};
    full_addr[0] = 16'h0110;
    full_addr[1] = 16'h0220;
    full_addr[2] = 16'h0330;
    full_addr[3] = 16'h0440;

    // Reset with garbage on every input.
    rst = 1'b1;
    lq.flush = 1'b1;
    issue(1'b1, 3'd5, 16'hA5A5, 16'h5A5A, 3'd6);
    lq.cdb_valid = 1'b1; lq.cdb_tag = 3'd5; lq.cdb_data = 16'h1111;
    lq.dmem_resp = 1'b1; lq.dmem_rdata = 16'h2222; lq.res_ack = 1'b1;
    tick();
    tick();
    check("rst_full", 32'(lq.full), 0);
    check("rst_empty", 32'(lq.empty), 1);
    check("rst_dmem_read", 32'(lq.dmem_read), 0);
    check("rst_dmem_address", 32'(lq.dmem_address), 0);
    check("rst_res_valid", 32'(lq.res_valid), 0);
    check("rst_res_tag", 32'(lq.res_tag), 0);
    check("rst_res_data", 32'(lq.res_data), 0);
    rst = 1'b0;
    lq.flush = 1'b0; lq.issue_we = 1'b0; lq.cdb_valid = 1'b0;
    lq.dmem_resp = 1'b0; lq.res_ack = 1'b0;
    resp_en = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Fill with four dependent loads, then resolve them in reverse order.
    dlat = 1;
    for (int t = 1; t <= 4; t++) begin
      issue(1'b0, 3'(t), 16'hFFFF, 16'(t * 16'h10), 3'(t));
      sb.push_back('{tag: 3'(t), data: mem_fn(full_addr[t-1])});
      tick();
    end
    lq.issue_we = 1'b0;
    check("full_set", 32'(lq.full), 1);
    check("full_not_empty", 32'(lq.empty), 0);
    issue(1'b1, 3'd0, 16'h7000, 16'h0000, 3'd7);
    tick();
    lq.issue_we = 1'b0;
    check("full_ignored", 32'(lq.full), 1);
    check("full_no_read", 32'(lq.dmem_read), 0);
    for (int t = 4; t >= 1; t--) begin
      lq.cdb_valid = 1'b1;
      lq.cdb_tag   = 3'(t);
      lq.cdb_data  = 16'(t * 16'h100);
      tick();
    end
    lq.cdb_valid = 1'b0;
    drain(4);
    tick();
    tick();
    check("full_drained_empty", 32'(lq.empty), 1);
    check("full_no_extra", 32'(lq.res_valid), 0);

    // Flush while a read is outstanding; an issue in the flush cycle is dropped.
    resp_en = 1'b0;
    lq.dmem_resp = 1'b0;
    issue(1'b1, 3'd0, 16'h0400, 16'h0000, 3'd2);
    tick();
    lq.issue_we = 1'b0;
    tick();
    check("flush_pre_read", 32'(lq.dmem_read), 1);
    lq.flush = 1'b1;
    issue(1'b1, 3'd0, 16'h0500, 16'h0000, 3'd3);
    tick();
    lq.flush = 1'b0;
    lq.issue_we = 1'b0;
    check("flush_hold_read", 32'(lq.dmem_read), 1);
    check("flush_empty", 32'(lq.empty), 1);
    seen = lq.res_valid;
    tick();
    check("flush_hold_read2", 32'(lq.dmem_read), 1);
    lq.dmem_resp  = 1'b1;
    lq.dmem_rdata = 16'hDEAD;
    tick();
    lq.dmem_resp = 1'b0;
    check("flush_drain_done", 32'(lq.dmem_read), 0);
    for (int i = 0; i < 4; i++) begin
      if (lq.res_valid || lq.dmem_read) seen = 1'b1;
      tick();
    end
    check("flush_no_result", 32'(seen), 0);
    check("flush_empty2", 32'(lq.empty), 1);
    resp_en = 1'b1;
    run_vec(vecs[0]);

    // Pointer wrap: three batches of two back-to-back loads.
    dlat = 1;
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 2; j++) begin
        issue(1'b1, 3'd0, 16'(16'h3000 + k * 16'h100), 16'(j), 3'(k * 2 + j));
        sb.push_back('{tag: 3'(k * 2 + j),
                       data: mem_fn(16'(16'h3000 + k * 16'h100 + j))});
        tick();
      end
      lq.issue_we = 1'b0;
      drain(2);
      check("wrap_empty", 32'(lq.empty), 1);
    end
    check("sb_leftover", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
